stream_reader_p: RTL and testbench



---
 rtl/stream_reader_p.sv | 189 ++++++++++++++++++
 tb/tb_stream_reader_p.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_reader_p.sv
// stream_reader_p: fills a STREAMS x WORDS frame from paged RAM, then serves
// it to SPLIT one word per handshake. Optional: READER_OVERRUN_EN.
module stream_reader_p #(
  parameter int DATA_W  = 18,
  parameter int WORDS   = 16,
  parameter int STREAMS = 3,
  parameter int PAGES   = 8,
  parameter int RD_LAT  = 4,
  parameter int TX_HOLD = 4,
  localparam int FRAME  = STREAMS * WORDS,
  localparam int ADDR_W = $clog2(PAGES * FRAME),
  localparam int SW     = (STREAMS > 1) ? $clog2(STREAMS) : 1,
  localparam int PW     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              reqMFK,
  input  logic [DATA_W-1:0] din,
  input  logic              reqSPLIT,
  output logic [ADDR_W-1:0] addrRD,
  output logic              readEN,
  output logic [DATA_W-1:0] dout,
  output logic              TXen,
  output logic              RXdone,
  output logic [SW-1:0]     cntStream,
  output logic [PW-1:0]     page,
  output logic              overrun
);

  localparam int WW = $clog2(WORDS);
  localparam int IW = $clog2(FRAME);
  localparam int RW = $clog2(RD_LAT + 2);
  localparam int TW = $clog2(TX_HOLD + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_SPL_HI, S_TX, S_SPL_LO, S_MFK_LO
  } state_t;

  state_t r_state, w_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic              r_rden;
  logic [DATA_W-1:0] r_dout;
  logic              r_txen;
  logic              r_rxdone;
  logic [WW-1:0]     r_w;
  logic [SW-1:0]     r_s;
  logic [PW-1:0]     r_page;
  logic [IW-1:0]     r_k;
  logic [RW-1:0]     r_rc;
  logic [TW-1:0]     r_tc;
  logic [DATA_W-1:0] r_buf [FRAME];

  logic          w_rd_end;
  logic          w_tx_end;
  logic          w_last;
  logic          w_wrap;
  logic          w_k_last;
  logic [WW-1:0] w_w_inc;
  logic [SW-1:0] w_s_inc;
  logic [IW-1:0] w_bidx;

  function automatic logic [ADDR_W-1:0] f_addr(
    input logic [PW-1:0] p,
    input logic [SW-1:0] s,
    input logic [WW-1:0] w
  );
    return (ADDR_W'(p) * ADDR_W'(STREAMS) + ADDR_W'(s))
           * ADDR_W'(WORDS) + ADDR_W'(w);
  endfunction

  assign w_rd_end = (r_state == S_READ) && (r_rc == RW'(RD_LAT + 1));
  assign w_tx_end = (r_state == S_TX) && (r_tc == TW'(TX_HOLD + 1));
  assign w_wrap   = (r_w == WW'(WORDS - 1));
  assign w_last   = w_wrap && (r_s == SW'(STREAMS - 1));
  assign w_k_last = (r_k == IW'(FRAME - 1));
  assign w_w_inc  = w_wrap ? '0 : r_w + WW'(1);
  assign w_s_inc  = w_wrap ? r_s + SW'(1) : r_s;
  assign w_bidx   = IW'(r_s) * IW'(WORDS) + IW'(r_w);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (reqMFK) w_nxt = S_READ;
      S_READ:   if (w_rd_end && w_last) w_nxt = S_SPL_HI;
      S_SPL_HI: if (reqSPLIT) w_nxt = S_TX;
      S_TX:     if (w_tx_end) w_nxt = w_k_last ? S_MFK_LO : S_SPL_LO;
      S_SPL_LO: if (!reqSPLIT) w_nxt = S_SPL_HI;
      S_MFK_LO: if (!reqMFK) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_addr   <= '0;
      r_rden   <= 1'b0;
      r_dout   <= '0;
      r_txen   <= 1'b0;
      r_rxdone <= 1'b0;
      r_w      <= '0;
      r_s      <= '0;
      r_page   <= '0;
      r_k      <= '0;
      r_rc     <= '0;
      r_tc     <= '0;
    end else begin
      r_rxdone <= 1'b0;
      unique case (r_state)
        S_IDLE: if (reqMFK) begin
          r_w    <= '0;
          r_s    <= '0;
          r_rc   <= '0;
          r_addr <= f_addr(r_page, '0, '0);
        end
        S_READ: begin
          r_rc <= r_rc + RW'(1);
          if (r_rc == '0) r_rden <= 1'b1;
          if (r_rc == RW'(RD_LAT)) r_rden <= 1'b0;
          if (w_rd_end) begin
            r_rc <= '0;
            if (w_last) begin
              r_w      <= '0;
              r_s      <= '0;
              r_page   <= r_page + PW'(1);
              r_rxdone <= 1'b1;
            end else begin
              r_w    <= w_w_inc;
              r_s    <= w_s_inc;
              r_addr <= f_addr(r_page, w_s_inc, w_w_inc);
            end
          end
        end
        S_TX: begin
          r_tc <= r_tc + TW'(1);
          if (r_tc == '0) r_dout <= r_buf[r_k];
          if (r_tc == TW'(1)) r_txen <= 1'b1;
          if (w_tx_end) begin
            r_txen <= 1'b0;
            r_tc   <= '0;
            r_k    <= w_k_last ? '0 : r_k + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Capture on the edge that ends the last readEN-high cycle
  always_ff @(posedge clk) begin
    if (r_state == S_READ && r_rc == RW'(RD_LAT))
      r_buf[w_bidx] <= din;
  end

`ifdef READER_OVERRUN_EN
  logic r_mfk_d;
  logic r_ovr;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_mfk_d <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_mfk_d <= reqMFK;
      if (reqMFK && !r_mfk_d &&
          r_state != S_IDLE && r_state != S_MFK_LO)
        r_ovr <= 1'b1;
    end
  end

  assign overrun = r_ovr;
`else
  assign overrun = 1'b0;
`endif

  assign addrRD    = r_addr;
  assign readEN    = r_rden;
  assign dout      = r_dout;
  assign TXen      = r_txen;
  assign RXdone    = r_rxdone;
  assign cntStream = r_s;
  assign page      = r_page;

endmodule

// File: tb/tb_stream_reader_p.sv
// tb_stream_reader_p: random RAM contents and handshake gaps, checked
// against a frame-level model of pages, addresses and word order.
module tb_stream_reader_p;

  localparam int DATA_W  = 18;
  localparam int WORDS   = 16;
  localparam int STREAMS = 3;
  localparam int PAGES   = 8;
  localparam int RD_LAT  = 4;
  localparam int TX_HOLD = 4;
  localparam int FRAME   = STREAMS * WORDS;
  localparam int ADDR_W  = $clog2(PAGES * FRAME);
  localparam int SW      = (STREAMS > 1) ? $clog2(STREAMS) : 1;
  localparam int PW      = (PAGES > 1) ? $clog2(PAGES) : 1;

  logic              clk = 1'b0;
  logic              nRST = 1'b0;
  logic              reqMFK = 1'b0;
  logic              reqSPLIT = 1'b0;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] addrRD;
  logic              readEN;
  logic [DATA_W-1:0] dout;
  logic              TXen;
  logic              RXdone;
  logic [SW-1:0]     cntStream;
  logic [PW-1:0]     page;
  logic              overrun;

  logic [DATA_W-1:0] ram [2**ADDR_W];
  int total = 0;
  int bad = 0;
  int exp_page = 0;
  int exp_ovr = 0;

  stream_reader_p dut (
    .clk(clk), .nRST(nRST), .reqMFK(reqMFK), .din(din),
    .reqSPLIT(reqSPLIT), .addrRD(addrRD), .readEN(readEN),
    .dout(dout), .TXen(TXen), .RXdone(RXdone),
    .cntStream(cntStream), .page(page), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // RAM drives valid data only while enabled
  assign din = readEN ? ram[addrRD] : '1;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_addr"}, addrRD, 0);
    chk({pfx, "_rden"}, readEN, 0);
    chk({pfx, "_dout"}, dout, 0);
    chk({pfx, "_txen"}, TXen, 0);
    chk({pfx, "_rxdn"}, RXdone, 0);
    chk({pfx, "_strm"}, cntStream, 0);
    chk({pfx, "_page"}, page, 0);
    chk({pfx, "_ovr"}, overrun, 0);
  endtask

  task automatic read_frame(input bit drop_mfk, input int rst_at,
                            output bit aborted);
    int pulses = 0, len = 0, badlen = 0, badgap = 0;
    int rise = 0, lasthi = 0, rxc = 0, rxn = 0;
    int base = exp_page * FRAME;
    aborted = 1'b0;
    reqMFK = 1'b1;
    for (int cyc = 0; cyc < FRAME * (RD_LAT + 2) + 40; cyc++) begin
      @(negedge clk);
      if (readEN) begin
        if (len == 0) begin
          if (pulses > 0 && cyc - rise != RD_LAT + 2) badgap++;
          chk("addr", addrRD, base + pulses);
          chk("strm", cntStream, pulses / WORDS);
          rise = cyc;
          pulses++;
          if (drop_mfk) reqMFK = 1'b0;
          if (pulses == rst_at + 1) begin
            #2 nRST = 1'b0;
            reqMFK = 1'b0;
            #1 chk_zero("rst");
            @(negedge clk);
            nRST = 1'b1;
            exp_page = 0;
            exp_ovr = 0;
            aborted = 1'b1;
            return;
          end
        end
        len++;
        lasthi = cyc;
      end else if (len != 0) begin
        if (len != RD_LAT) badlen++;
        len = 0;
      end
      if (RXdone) begin
        rxn++;
        if (rxn == 1) rxc = cyc;
      end
      if (rxn > 0 && cyc >= rxc + 2) break;
    end
    exp_page = (exp_page + 1) % PAGES;
    chk("pulses", pulses, FRAME);
    chk("rdlen", badlen, 0);
    chk("rdgap", badgap, 0);
    chk("rxcnt", rxn, 1);
    chk("rxlat", rxc - lasthi, 2);
    chk("page", page, exp_page);
  endtask

  task automatic tx_frame(input int base, input int hold_word,
                          input int ovr_word);
    for (int k = 0; k < FRAME; k++) begin
      int waitc = 0, len = 0, dbad = 0, extra = 0;
      reqSPLIT = 1'b1;
      while (!TXen && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      if (!TXen) begin
        chk("txseen", 0, 1);
        reqSPLIT = 1'b0;
        return;
      end
      if (k == ovr_word) begin
        reqMFK = 1'b1;
`ifdef READER_OVERRUN_EN
        exp_ovr = 1;
`endif
      end
      chk("dout", dout, ram[base + k]);
      while (TXen && len < 20) begin
        if (dout != ram[base + k]) dbad++;
        len++;
        @(negedge clk);
      end
      chk("txlen", len, TX_HOLD);
      chk("dhold", dbad, 0);
      if (k == hold_word) begin
        repeat (15) begin
          @(negedge clk);
          if (TXen) extra++;
        end
        chk("splhold", extra, 0);
      end
      reqSPLIT = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic end_frame();
    int n = 0;
    reqMFK = 1'b1;
    repeat ($urandom_range(5, 20)) begin
      @(negedge clk);
      if (readEN || RXdone || TXen) n++;
    end
    chk("mfkhold", n, 0);
    chk("ovr", overrun, exp_ovr);
    reqMFK = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input bit drop_mfk, input int rst_at,
                           input int hold_word, input int ovr_word);
    bit ab;
    int base = exp_page * FRAME;
    read_frame(drop_mfk, rst_at, ab);
    if (ab) return;
    tx_frame(base, hold_word, ovr_word);
    end_frame();
  endtask

  initial begin
    foreach (ram[i]) ram[i] = DATA_W'($urandom);
    #12 chk_zero("init");
    nRST = 1'b1;
    @(negedge clk);
    // Frames 0..7 cover every page; frame 8 must wrap to address 0
    for (int f = 0; f < 9; f++)
      run_frame(1'b0, -1, (f == 0) ? 5 : -1, -1);
    run_frame(1'b1, -1, -1, 10);
    run_frame(1'b0, 20, -1, -1);
    chk("postrst_ovr", overrun, 0);
    run_frame(1'b0, -1, $urandom_range(0, FRAME - 1), -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
